// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator core: opcode/state encodings and
// the active-low seven-segment decoder.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } opcode_t;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RES = 2'd3
    } state_t;

    localparam int OPC_COUNT = 6;

    // Segment order gfedcba, a lit segment is 0.
    function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, stability down-counter and a single
// registered pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_db_q;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    // The level flips on the DEBOUNCE_CYC-th consecutive differing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_db_q  <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= CNT_LOAD;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_pulse <= r_db & ~r_db_q;
            if (r_sync2 == r_db) begin
                r_cnt <= CNT_LOAD;
            end else if (r_cnt == '0) begin
                r_db  <= r_sync2;
                r_cnt <= CNT_LOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/calc_core_param.sv
// Calculator core: debounced buttons drive an operand/opcode entry FSM, a six-op
// ALU with chaining and flags, and a multiplexed hex display.
//
//   state | meaning
//   S_A   | waiting for operand A (enter latches sw)
//   S_B   | waiting for operand B (enter latches sw)
//   S_OP  | op button steps opcode, enter computes the result
//   S_RES | result shown; enter restarts, op button chains result into A
module calc_core_param
    import calc_pkg::*;
#(
    parameter int W            = 4,
    parameter int NUM_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 100000,
    parameter int REFRESH_DIV  = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          sw,
    input  logic [2:0]            btn,
    output logic [2*W-1:0]        led,
    output logic [1:0]            flags,
    output logic [1:0]            state,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            segment
);

    localparam int LW = 2 * W;
    localparam int DW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [RW-1:0] REF_LOAD = RW'(REFRESH_DIV - 1);

    logic [2:0] w_p;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_db (
                .clk  (clk),
                .rst  (rst),
                .raw  (btn[gi]),
                .pulse(w_p[gi])
            );
        end
    endgenerate

    state_t        r_state,   w_state_nx;
    logic [W-1:0]  r_a,       w_a_nx;
    logic [W-1:0]  r_b,       w_b_nx;
    opcode_t       r_opc,     w_opc_nx;
    logic [LW-1:0] r_led,     w_led_nx;
    logic [1:0]    r_flags,   w_flags_nx;

    logic [W:0]    w_sum;
    logic [LW-1:0] w_alu;
    logic [1:0]    w_alu_flags;
    opcode_t       w_opc_inc;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Flags are {neg, carry}; ops that do not define a flag leave it at 0.
    always_comb begin
        w_alu       = '0;
        w_alu_flags = '0;
        case (r_opc)
            OP_ADD: begin
                w_alu       = LW'(w_sum);
                w_alu_flags = {1'b0, w_sum[W]};
            end
            OP_SUB: begin
                w_alu       = {{W{1'b0}}, r_a} - {{W{1'b0}}, r_b};
                w_alu_flags = {(r_a < r_b), 1'b0};
            end
            OP_MUL: w_alu = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
            OP_AND: w_alu = {{W{1'b0}}, r_a & r_b};
            OP_OR:  w_alu = {{W{1'b0}}, r_a | r_b};
            OP_XOR: w_alu = {{W{1'b0}}, r_a ^ r_b};
            default: begin
                w_alu       = '0;
                w_alu_flags = '0;
            end
        endcase
    end

    assign w_opc_inc = (int'(r_opc) == OPC_COUNT - 1) ? OP_ADD : opcode_t'(r_opc + 3'd1);

    // Clear outranks enter, and enter outranks the op/chain button.
    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_opc_nx   = r_opc;
        w_led_nx   = r_led;
        w_flags_nx = r_flags;
        if (w_p[2]) begin
            w_state_nx = S_A;
            w_a_nx     = '0;
            w_b_nx     = '0;
            w_opc_nx   = OP_ADD;
            w_led_nx   = '0;
            w_flags_nx = '0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_p[0]) begin
                        w_a_nx     = sw;
                        w_state_nx = S_B;
                    end
                end
                S_B: begin
                    if (w_p[0]) begin
                        w_b_nx     = sw;
                        w_state_nx = S_OP;
                    end
                end
                S_OP: begin
                    if (w_p[0]) begin
                        w_led_nx   = w_alu;
                        w_flags_nx = w_alu_flags;
                        w_state_nx = S_RES;
                    end else if (w_p[1]) begin
                        w_opc_nx = w_opc_inc;
                    end
                end
                S_RES: begin
                    if (w_p[0]) begin
                        w_state_nx = S_A;
                    end else if (w_p[1]) begin
                        w_a_nx     = r_led[W-1:0];
                        w_state_nx = S_B;
                    end
                end
                default: w_state_nx = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_opc   <= OP_ADD;
            r_led   <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_opc   <= w_opc_nx;
            r_led   <= w_led_nx;
            r_flags <= w_flags_nx;
        end
    end

    logic [DW-1:0]         w_disp;
    logic [3:0]            w_nib;
    logic [RW-1:0]         r_ref_cnt;
    logic [IW-1:0]         r_idx;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    always_comb begin
        w_disp = '0;
        case (r_state)
            S_A, S_B: w_disp = DW'(sw);
            S_OP:     w_disp = DW'(r_opc);
            S_RES:    w_disp = DW'(r_led);
            default:  w_disp = '0;
        endcase
    end

    assign w_nib = w_disp[{r_idx, 2'b00} +: 4];

    // Digits stay dark until the first terminal count, then advance one per period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt <= REF_LOAD;
            r_idx     <= '0;
            r_an      <= '1;
            r_seg     <= 7'h7F;
        end else if (r_ref_cnt == '0) begin
            r_ref_cnt <= REF_LOAD;
            r_an      <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg     <= hex7seg(w_nib);
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_ref_cnt <= r_ref_cnt - 1'b1;
        end
    end

    assign led     = r_led;
    assign flags   = r_flags;
    assign state   = r_state;
    assign an      = r_an;
    assign segment = r_seg;

endmodule
